// File: rtl/dft_pkg.sv
// Shared constants and helpers for the DFT front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package dft_pkg;

    // Component indices of a complex sample, shared with computeMatrix.
    localparam int RE = 0;
    localparam int IM = 1;

    // Width of a 0..n-1 index; never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dft_frame_collector_if.sv
// Sample stream in, parallel complex frame out, plus framing-error pulse.
// Latency: n/a (signal bundle only).
// Backpressure: s_ready/m_ready valid-ready on each side.
interface dft_frame_collector_if #(
    parameter int N = 8,
    parameter int W = 15
);
    logic                s_valid;
    logic                s_ready;
    logic signed [W:0]   s_re;
    logic signed [W:0]   s_im;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic signed [W:0]   x_o [N][2];
    logic                err_o;

    // Collector side: consumes samples, produces frames.
    modport slave (
        input  s_valid, s_re, s_im, s_last, m_ready,
        output s_ready, m_valid, x_o, err_o
    );

    // Environment side: produces samples, consumes frames.
    modport master (
        output s_valid, s_re, s_im, s_last, m_ready,
        input  s_ready, m_valid, x_o, err_o
    );
endinterface

// File: rtl/dft_frame_bank.sv
// One N-entry complex sample register bank, all entries visible in parallel.
// Latency: a write is visible on the outputs the cycle after we.
// Backpressure: none; the caller decides when to write.
module dft_frame_bank
    import dft_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 15,
    parameter int AW = idx_width(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W:0]   wre,
    input  logic signed [W:0]   wim,
    output logic signed [W:0]   q_re [N],
    output logic signed [W:0]   q_im [N]
);

    // Store one sample bit-exact at waddr; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                q_re[i] <= '0;
                q_im[i] <= '0;
            end
        end else if (we) begin
            q_re[waddr] <= wre;
            q_im[waddr] <= wim;
        end
    end

endmodule

// File: rtl/dft_frame_collector.sv
// Ping-pong collector: serial complex samples into N-wide frames for the DFT.
// Latency: m_valid rises the cycle after the Nth sample of a frame is accepted.
// Backpressure: s_ready drops only when both banks hold unconsumed frames.
module dft_frame_collector
    import dft_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dft_frame_collector_if.slave  bus
);

    localparam int AW = idx_width(N);

    logic              wb;
    logic              rb;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [AW-1:0]     wr_idx;
    logic              err_q;
    logic              accept;
    logic              at_end;
    logic              pop;
    logic signed [W:0] b0_re [N];
    logic signed [W:0] b0_im [N];
    logic signed [W:0] b1_re [N];
    logic signed [W:0] b1_im [N];

    assign bus.s_ready = !full[wb];
    assign bus.m_valid = full[rb];
    assign bus.err_o   = err_q;

    assign accept = bus.s_valid && bus.s_ready;
    assign at_end = (wr_idx == AW'(N - 1));
    assign pop    = full[rb] && bus.m_ready;

    // Completion and consumption always hit different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (pop)
            full_nxt[rb] = 1'b0;
        if (accept && at_end)
            full_nxt[wb] = 1'b1;
    end

    // Pointers, write index and framing check; short frames are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= '0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            wr_idx <= '0;
            err_q  <= 1'b0;
        end else begin
            full  <= full_nxt;
            err_q <= 1'b0;
            if (pop)
                rb <= !rb;
            if (accept) begin
                if (at_end) begin
                    wb     <= !wb;
                    wr_idx <= '0;
                    err_q  <= !bus.s_last;
                end else if (bus.s_last) begin
                    wr_idx <= '0;
                    err_q  <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + AW'(1);
                end
            end
        end
    end

    dft_frame_bank #(.N(N), .W(W), .AW(AW)) u_b0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && !wb),
        .waddr (wr_idx),
        .wre   (bus.s_re),
        .wim   (bus.s_im),
        .q_re  (b0_re),
        .q_im  (b0_im)
    );

    dft_frame_bank #(.N(N), .W(W), .AW(AW)) u_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && wb),
        .waddr (wr_idx),
        .wre   (bus.s_re),
        .wim   (bus.s_im),
        .q_re  (b1_re),
        .q_im  (b1_im)
    );

    // Present the read bank straight from its registers.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.x_o[i][RE] = rb ? b1_re[i] : b0_re[i];
            bus.x_o[i][IM] = rb ? b1_im[i] : b0_im[i];
        end
    end

endmodule

// File: tb/tb_dft_frame_collector.sv
module tb_dft_frame_collector;
    import dft_pkg::*;

    localparam int N = 8;
    localparam int W = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dft_frame_collector_if #(.N(N), .W(W)) bus ();

    dft_frame_collector #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit stalled;

    // Offer one sample and hold it until accepted (bounded wait).
    task automatic push(input logic signed [W:0] re, input logic signed [W:0] im, input logic last);
        bus.s_valid = 1'b1;
        bus.s_re    = re;
        bus.s_im    = im;
        bus.s_last  = last;
        stalled     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.s_ready) begin
                @(posedge clk); #1;
                return;
            end
            stalled = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        $display("FAIL push_timeout: s_ready stayed %0b, required 1 within 50 cycles", bus.s_ready);
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL rst_mvalid_in_reset: got %0b want 0", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.err_o !== 1'b0) $display("FAIL rst_err: got %0b want 0", bus.err_o); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL rst_sready: got %0b want 1", bus.s_ready); else pass_cnt++;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL rst_mvalid: got %0b want 0", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.x_o[5][IM] !== 16'sd0) $display("FAIL rst_xo: got %0d want 0", bus.x_o[5][IM]); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        bit err_seen = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(16'(i), 16'(-i), i == 8);
            if (bus.err_o !== 1'b0) err_seen = 1'b1;
            if (i == 7) begin
                total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t1_mvalid_early: got %0b want 0", bus.m_valid); else pass_cnt++;
            end
        end
        total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL t1_mvalid: got %0b want 1", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.x_o[3][RE] !== 16'sd4) $display("FAIL t1_x3_re: got %0d want 4", bus.x_o[3][RE]); else pass_cnt++;
        total_cnt++; if (bus.x_o[3][IM] !== -16'sd4) $display("FAIL t1_x3_im: got %0d want -4", bus.x_o[3][IM]); else pass_cnt++;
        total_cnt++; if (bus.x_o[7][IM] !== -16'sd8) $display("FAIL t1_x7_im: got %0d want -8", bus.x_o[7][IM]); else pass_cnt++;
        total_cnt++; if (err_seen !== 1'b0) $display("FAIL t1_err: got %0b want 0", err_seen); else pass_cnt++;
        idle();
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t1_consumed: got %0b want 0", bus.m_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 16; k++)
            push(16'(100 + k), 16'(-(100 + k)), (k % 8) == 7);
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL t2_sready_full: got %0b want 0", bus.s_ready); else pass_cnt++;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd100) $display("FAIL t2_frame1: got %0d want 100", bus.x_o[0][RE]); else pass_cnt++;
        // Sample 17 waits while both banks are full.
        bus.s_valid = 1'b1; bus.s_re = 16'sd116; bus.s_im = -16'sd116; bus.s_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL t2_stall: got %0b want 0", bus.s_ready); else pass_cnt++;
        total_cnt++; if (bus.x_o[5][RE] !== 16'sd105) $display("FAIL t2_hold: got %0d want 105", bus.x_o[5][RE]); else pass_cnt++;
        total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL t2_hold_vld: got %0b want 1", bus.m_valid); else pass_cnt++;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd108) $display("FAIL t2_frame2: got %0d want 108", bus.x_o[0][RE]); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL t2_release: got %0b want 1", bus.s_ready); else pass_cnt++;
        for (int k = 16; k < 24; k++)
            push(16'(100 + k), 16'(-(100 + k)), (k % 8) == 7);
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL t2_full_again: got %0b want 0", bus.s_ready); else pass_cnt++;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd116) $display("FAIL t2_frame3_first: got %0d want 116", bus.x_o[0][RE]); else pass_cnt++;
        total_cnt++; if (bus.x_o[7][IM] !== -16'sd123) $display("FAIL t2_frame3_last: got %0d want -123", bus.x_o[7][IM]); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t2_drained: got %0b want 0", bus.m_valid); else pass_cnt++;
    endtask

    task automatic test_short_frame();
        for (int k = 0; k < 5; k++)
            push(16'(200 + k), 16'(k), k == 4);
        total_cnt++; if (bus.err_o !== 1'b1) $display("FAIL t3_err: got %0b want 1", bus.err_o); else pass_cnt++;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t3_mvalid: got %0b want 0", bus.m_valid); else pass_cnt++;
        idle();
        total_cnt++; if (bus.err_o !== 1'b0) $display("FAIL t3_err_pulse: got %0b want 0", bus.err_o); else pass_cnt++;
        for (int k = 5; k < 13; k++)
            push(16'(200 + k), 16'(k), k == 12);
        total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL t3_clean_vld: got %0b want 1", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd205) $display("FAIL t3_x0: got %0d want 205", bus.x_o[0][RE]); else pass_cnt++;
        total_cnt++; if (bus.x_o[7][RE] !== 16'sd212) $display("FAIL t3_x7: got %0d want 212", bus.x_o[7][RE]); else pass_cnt++;
        total_cnt++; if (bus.err_o !== 1'b0) $display("FAIL t3_clean_err: got %0b want 0", bus.err_o); else pass_cnt++;
        idle();
    endtask

    task automatic test_long_frame();
        for (int k = 0; k < 8; k++)
            push(16'(300 + k), 16'(-k), 1'b0);
        total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL t4_vld: got %0b want 1", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.err_o !== 1'b1) $display("FAIL t4_err: got %0b want 1", bus.err_o); else pass_cnt++;
        total_cnt++; if (bus.x_o[7][RE] !== 16'sd307) $display("FAIL t4_x7: got %0d want 307", bus.x_o[7][RE]); else pass_cnt++;
        push(16'sd308, -16'sd8, 1'b0);
        total_cnt++; if (bus.err_o !== 1'b0) $display("FAIL t4_err_once: got %0b want 0", bus.err_o); else pass_cnt++;
        for (int k = 9; k < 16; k++)
            push(16'(300 + k), 16'(-k), k == 15);
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd308) $display("FAIL t4_next_x0: got %0d want 308", bus.x_o[0][RE]); else pass_cnt++;
        total_cnt++; if (bus.x_o[7][IM] !== -16'sd15) $display("FAIL t4_next_x7: got %0d want -15", bus.x_o[7][IM]); else pass_cnt++;
        idle();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++)
            push(16'(400 + k), 16'(k + 1), 1'b0);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t5_mvalid_rst: got %0b want 0", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd0) $display("FAIL t5_xo_rst: got %0d want 0", bus.x_o[0][RE]); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t5_mvalid_hold: got %0b want 0", bus.m_valid); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++)
            push(16'(500 + k), 16'(-k), 1'b0);
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t5_no_stale: got %0b want 0", bus.m_valid); else pass_cnt++;
        for (int k = 4; k < 8; k++)
            push(16'(500 + k), 16'(-k), k == 7);
        total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL t5_vld: got %0b want 1", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.x_o[0][RE] !== 16'sd500) $display("FAIL t5_x0: got %0d want 500", bus.x_o[0][RE]); else pass_cnt++;
        total_cnt++; if (bus.x_o[4][RE] !== 16'sd504) $display("FAIL t5_x4: got %0d want 504", bus.x_o[4][RE]); else pass_cnt++;
        idle();
    endtask

    task automatic test_full_rate();
        logic [W:0] exp_re [N];
        logic [W:0] exp_im [N];
        int stall_cnt = 0;
        int err_cnt   = 0;
        int mism;
        bus.m_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = f * N + i;
                exp_re[i] = 16'(k * 1021 + 32769);
                exp_im[i] = 16'((k * 7919) ^ 16'hA5A5);
                push(exp_re[i], exp_im[i], i == N - 1);
                if (stalled) stall_cnt++;
                if (bus.err_o !== 1'b0) err_cnt++;
            end
            mism = 0;
            for (int i = 0; i < N; i++) begin
                if (bus.x_o[i][RE] !== exp_re[i]) mism++;
                if (bus.x_o[i][IM] !== exp_im[i]) mism++;
            end
            total_cnt++;
            if (mism != 0 || bus.m_valid !== 1'b1)
                $display("FAIL t6_frame%0d: %0d component mismatches, m_valid %0b; want 0 and 1", f, mism, bus.m_valid);
            else pass_cnt++;
        end
        idle();
        total_cnt++; if (stall_cnt != 0) $display("FAIL t6_stalls: got %0d want 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (err_cnt != 0) $display("FAIL t6_err: got %0d want 0", err_cnt); else pass_cnt++;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL t6_drained: got %0b want 0", bus.m_valid); else pass_cnt++;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_re    = '0;
        bus.s_im    = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_async_reset();
        test_full_rate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
